uart_echo_initiator: RTL

Host-side initiator for the UART byte-echo link. On `start` it transmits a programmable run of bytes on its serial `tx`, receives each reply on `rx`, and checks that every reply equals the sent byte plus one (mod 256). It sits at the far end of the serial line from the FPGA UART echo top and serves as an on-chip self-test master and a bench stimulus/checker. It contains its own baud tick generator, a 16x-oversampled serializer and deserializer, and a control FSM.

---
 rtl/uart_echo_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_initiator.sv
// UART echo initiator: sends a run of bytes on tx, checks rx replies == byte+1.
// Optional reply timeout under `UART_ECHO_INIT_TIMEOUT_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   start, i_seed[7:0], i_count[7:0] : run request
//   rx / tx                          : serial line, idle high
//   o_busy, o_done, o_pass           : run status
//   o_err_cnt[7:0], o_rx_data[7:0]   : error count, last reply byte
module uart_echo_initiator #(
   parameter int DBIT        = 8,
   parameter int SB_TICK     = 16,
   parameter int DVSR        = 163,
   parameter int DVSR_BIT    = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] i_seed,
   input  logic [7:0] i_count,
   input  logic       rx,
   output logic       tx,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [7:0] o_err_cnt,
   output logic [7:0] o_rx_data
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

   // ---------------- tick generator ----------------
   logic [DVSR_BIT-1:0] tick_cnt;
   logic                tick;

   assign tick = (tick_cnt == DVSR_BIT'(DVSR - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // ---------------- serializer ----------------
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } ser_t;

   ser_t            tx_st;
   logic [SW-1:0]   tx_s;
   logic [NW-1:0]   tx_n;
   logic [DBIT-1:0] tx_b;
   logic            tx_pend;
   logic            tx_done;
   logic            tx_load;
   logic [7:0]      cur;

   // A load is held pending until the next tick so every bit
   // spans whole tick periods.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_st   <= S_IDLE;
         tx_s    <= '0;
         tx_n    <= '0;
         tx_b    <= '0;
         tx_pend <= 1'b0;
         tx_done <= 1'b0;
         tx      <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         if (tx_load) begin
            tx_pend <= 1'b1;
            tx_b    <= DBIT'(cur);
         end
         unique case (tx_st)
            S_IDLE: begin
               if ((tx_pend || tx_load) && tick) begin
                  tx_st   <= S_START;
                  tx_s    <= '0;
                  tx_pend <= 1'b0;
                  tx      <= 1'b0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (tx_s == SW'(15)) begin
                     tx_st <= S_DATA;
                     tx_s  <= '0;
                     tx_n  <= '0;
                     tx    <= tx_b[0];
                  end else begin
                     tx_s <= tx_s + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (tx_s == SW'(15)) begin
                     tx_s <= '0;
                     tx_b <= tx_b >> 1;
                     if (tx_n == NW'(DBIT - 1)) begin
                        tx_st <= S_STOP;
                        tx    <= 1'b1;
                     end else begin
                        tx_n <= tx_n + 1'b1;
                        tx   <= tx_b[1];
                     end
                  end else begin
                     tx_s <= tx_s + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (tx_s == SW'(SB_TICK - 1)) begin
                     tx_st   <= S_IDLE;
                     tx_done <= 1'b1;
                  end else begin
                     tx_s <= tx_s + 1'b1;
                  end
               end
            end
            default: tx_st <= S_IDLE;
         endcase
      end
   end

   // ---------------- deserializer ----------------
   typedef enum logic [1:0] {
      R_IDLE, R_START, R_DATA, R_STOP
   } des_t;

   logic            rx_m;
   logic            rx_s;
   logic            rx_p;
   des_t            rx_st;
   logic [3:0]      rx_c;
   logic [NW-1:0]   rx_n;
   logic [DBIT-1:0] rx_b;
   logic            rx_done;
   logic            rx_ferr;
   logic [7:0]      rx_byte;

   assign rx_byte = 8'(rx_b);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_p    <= 1'b1;
         rx_st   <= R_IDLE;
         rx_c    <= '0;
         rx_n    <= '0;
         rx_b    <= '0;
         rx_done <= 1'b0;
         rx_ferr <= 1'b0;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_p    <= rx_s;
         rx_done <= 1'b0;
         unique case (rx_st)
            R_IDLE: begin
               // edge, not level: a low stop bit must not restart a frame
               if (rx_p && !rx_s) begin
                  rx_st <= R_START;
                  rx_c  <= '0;
               end
            end
            R_START: begin
               if (tick) begin
                  if (rx_c == 4'd7) begin
                     rx_c <= '0;
                     rx_n <= '0;
                     rx_st <= rx_s ? R_IDLE : R_DATA;
                  end else begin
                     rx_c <= rx_c + 1'b1;
                  end
               end
            end
            R_DATA: begin
               if (tick) begin
                  if (rx_c == 4'd15) begin
                     rx_c <= '0;
                     rx_b <= {rx_s, rx_b[DBIT-1:1]};
                     if (rx_n == NW'(DBIT - 1)) begin
                        rx_st <= R_STOP;
                     end else begin
                        rx_n <= rx_n + 1'b1;
                     end
                  end else begin
                     rx_c <= rx_c + 1'b1;
                  end
               end
            end
            R_STOP: begin
               if (tick) begin
                  if (rx_c == 4'd15) begin
                     rx_st   <= R_IDLE;
                     rx_done <= 1'b1;
                     rx_ferr <= ~rx_s;
                  end else begin
                     rx_c <= rx_c + 1'b1;
                  end
               end
            end
            default: rx_st <= R_IDLE;
         endcase
      end
   end

   // ---------------- control FSM ----------------
   typedef enum logic [2:0] {
      IDLE, SEND, WAIT_RX, CHECK, DONE
   } st_t;

   st_t        st;
   logic [7:0] cnt;
   logic [7:0] err_inc;
   logic       bad;

   assign err_inc = (o_err_cnt == 8'hFF) ? o_err_cnt
                                         : o_err_cnt + 8'd1;
   assign bad     = (rx_byte != 8'(cur + 8'd1)) || rx_ferr;

`ifdef UART_ECHO_INIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
`else
   if (TIMEOUT_CYC < 1) begin : g_to_off
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= IDLE;
         cur       <= '0;
         cnt       <= '0;
         tx_load   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_pass    <= 1'b0;
         o_err_cnt <= '0;
         o_rx_data <= '0;
`ifdef UART_ECHO_INIT_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         tx_load <= 1'b0;
         o_done  <= 1'b0;
         unique case (st)
            IDLE: begin
               if (start) begin
                  o_busy <= 1'b1;
                  o_pass <= 1'b0;
                  if (i_count == 8'd0) begin
                     st <= DONE;
                  end else begin
                     cur       <= i_seed;
                     cnt       <= i_count;
                     o_err_cnt <= '0;
                     tx_load   <= 1'b1;
                     st        <= SEND;
                  end
               end
            end
            SEND: begin
`ifdef UART_ECHO_INIT_TIMEOUT_EN
               to_cnt <= '0;
`endif
               // replies completing before WAIT_RX are dropped
               if (tx_done) st <= WAIT_RX;
            end
            WAIT_RX: begin
               if (rx_done) begin
                  st <= CHECK;
`ifdef UART_ECHO_INIT_TIMEOUT_EN
               end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  o_err_cnt <= err_inc;
                  cur       <= cur + 8'd1;
                  cnt       <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     st <= DONE;
                  end else begin
                     tx_load <= 1'b1;
                     st      <= SEND;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            CHECK: begin
               if (bad) o_err_cnt <= err_inc;
               o_rx_data <= rx_byte;
               cur       <= cur + 8'd1;
               cnt       <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  st <= DONE;
               end else begin
                  tx_load <= 1'b1;
                  st      <= SEND;
               end
            end
            DONE: begin
               o_done <= 1'b1;
               o_pass <= (o_err_cnt == 8'd0);
               o_busy <= 1'b0;
               st     <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
